// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions.
// Word size defaults and sampler FSM state encoding.
package rsa_pkg;

  localparam int RSA_WORD_WIDTH = 512;
  localparam int RSA_DECIMATE   = 512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } samp_state_t;

endpackage

// File: rtl/rand_candidate_sampler.sv
// Samples a decimated LFSR word, health-checks it and
// conditions it into an RSA prime candidate.
module rand_candidate_sampler
  import rsa_pkg::*;
#(
  parameter int WORD_WIDTH = RSA_WORD_WIDTH,
  parameter int DECIMATE   = RSA_DECIMATE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] rand_in,
  input  logic                  start,
  input  logic                  cont,
  output logic [WORD_WIDTH-1:0] cand,
  output logic                  cand_valid,
  input  logic                  cand_ready,
  output logic                  busy,
  output logic                  fault,
  output logic [31:0]           sample_cnt
);

  localparam int CW = $clog2(DECIMATE + 1);
  localparam logic [CW-1:0] LOAD = CW'(DECIMATE);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Top two bits give full modulus length, bit 0 makes it odd.
  localparam logic [WORD_WIDTH-1:0] FORCE =
    {2'b11, {(WORD_WIDTH-3){1'b0}}, 1'b1};

  samp_state_t           state;
  logic [CW-1:0]         cnt;
  logic                  cont_q;
  logic [WORD_WIDTH-1:0] prev_raw;

  logic accept;
  logic cap;
  logic bad;
  logic hs;

  assign accept = (state == ST_IDLE) && start && !fault;
  assign cap    = (state == ST_WAIT) && (cnt == ONE);
  assign bad    = (rand_in == prev_raw) || (rand_in == '0);
  assign hs     = (state == ST_HOLD) && cand_valid && cand_ready;
  assign busy   = (state != ST_IDLE);

  // Sequencing: idle -> decimation wait -> hold until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cont_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt    <= LOAD;
            cont_q <= cont;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cap) begin
            cnt   <= '0;
            state <= bad ? ST_IDLE : ST_HOLD;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_HOLD: begin
          if (hs) begin
            if (cont_q) begin
              cnt   <= LOAD;
              state <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture path: health check, conditioning and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_raw   <= '0;
      cand       <= '0;
      cand_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (cap) begin
        prev_raw <= rand_in;
        if (bad) begin
          fault <= 1'b1;
        end else begin
          cand       <= rand_in | FORCE;
          cand_valid <= 1'b1;
        end
      end else if (hs) begin
        cand_valid <= 1'b0;
      end
    end
  end

  // Completed handshakes, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
    end else if (hs) begin
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

endmodule

// File: doc/rand_candidate_sampler.md
RAND_CANDIDATE_SAMPLER -- requirements
Module: rand_candidate_sampler

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 512: width of the random word and of the candidate.
REQ-002 SHALL have parameter DECIMATE, default 512: clock cycles between samples, legal range >= 1, so every sample sees a fully refreshed LFSR word.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rand_in, input, WORD_WIDTH bits: free-running LFSR state.
REQ-006 SHALL have port start, input, 1 bit: request sampling; honoured only in IDLE with fault=0.
REQ-007 SHALL have port cont, input, 1 bit: continuous mode; captured when start is accepted.
REQ-008 SHALL have port cand, output, WORD_WIDTH bits: conditioned RSA prime candidate.
REQ-009 SHALL have port cand_valid, output, 1 bit: cand is valid.
REQ-010 SHALL have port cand_ready, input, 1 bit: consumer accepts cand.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port fault, output, 1 bit: sticky LFSR health failure.
REQ-013 SHALL have port sample_cnt, output, 32 bits: count of completed handshakes; wraps modulo 2^32.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and HOLD.
REQ-015 In IDLE, start=1 and fault=0 at an edge SHALL load the wait counter with DECIMATE, latch cont into cont_q, and move to WAIT.
REQ-016 WAIT SHALL decrement the counter once per cycle; the edge at which the counter reaches 0 is the capture edge, which occurs DECIMATE edges after start is accepted.
REQ-017 At the capture edge, health check: if raw = prev_raw or raw = 0, fault SHALL be set, the FSM SHALL go to IDLE, and cand/cand_valid SHALL stay unchanged.
REQ-018 Otherwise, at the capture edge, cand SHALL load raw with bits WORD_WIDTH-1, WORD_WIDTH-2 and 0 forced to 1, cand_valid SHALL go to 1, and the FSM SHALL go to HOLD.
REQ-019 prev_raw SHALL update to raw at every capture edge.
REQ-020 In HOLD, cand and cand_valid SHALL be stable while cand_ready=0; rand_in changes SHALL be ignored.
REQ-021 On a handshake (cand_valid & cand_ready at an edge), sample_cnt SHALL increment, cand_valid SHALL drop, and the FSM SHALL go to WAIT (counter reloaded) if cont_q=1, else to IDLE.
REQ-022 cand_ready without cand_valid SHALL have no effect.
REQ-023 start while busy=1 or fault=1 SHALL be ignored; start and a handshake on the same edge SHALL follow the handshake rule only.
REQ-024 A continuous run SHALL end only on a handshake with cont_q=0 (not reachable mid-run), on fault, or on reset.
REQ-025 cand_valid SHALL never be asserted while fault=1.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, cont_q 0, prev_raw 0, cand 0, cand_valid 0, busy 0, fault 0 and sample_cnt 0, immediately and regardless of clk.
REQ-027 Reset mid-WAIT or mid-HOLD SHALL abandon the operation; no handshake SHALL be counted.
REQ-028 fault SHALL clear only by rst.

Structure
REQ-029 WORD_WIDTH default and the state enum type SHALL live in the shared package rsa_pkg.
REQ-030 The wait counter width SHALL be $clog2(DECIMATE+1).
REQ-031 The block SHALL contain no sub-modules; the lfsr instance SHALL sit alongside it at the parent level, driving rand_in.

Verification (bench uses WORD_WIDTH=16, DECIMATE=16)
REQ-032 Reset check: rst pulse -> cand=0, cand_valid=0, busy=0, fault=0, sample_cnt=0.
REQ-033 Single sample: start=1 and cont=0 for one cycle, rand_in=16'h1234 at the capture edge, cand_ready=1 -> cand_valid rises 16 edges after start with cand=16'hD235, then IDLE and sample_cnt=1.
REQ-034 Backpressure: cand_ready=0 for 10 cycles while rand_in toggles -> cand and cand_valid hold; handshake on cycle 11 -> sample_cnt increments exactly once.
REQ-035 Continuous: cont=1, cand_ready=1, distinct nonzero rand_in values -> cand_valid pulses separated by 17 cycles; sample_cnt=3 after the third handshake.
REQ-036 Health: rand_in held at 16'h00FF over two captures -> first candidate delivered, fault=1 at the second capture edge, no second cand_valid, later start ignored; rand_in=0 at the first capture -> fault=1 immediately.
REQ-037 Reset mid-operation: rst asserted 5 cycles into WAIT -> busy=0 immediately, no cand_valid follows, sample_cnt=0.
